// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 64;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch,
    StMissWait,
    StHalt
  } ifu_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } fifo_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush, occupancy count and same-cycle push/pop at any fill level.
module ifu_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PtrW'(1);
      if (pop_i)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues 4-byte reads to the I-cache and buffers returned instructions.
// Optional misaligned-redirect trap: define IFU_MISALIGN_CHECK_EN.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic        out_fault,
`endif
  output logic [63:0] cache_addr,
  output logic        cache_read,
  output logic        cache_write,
  output logic [1:0]  cache_write_len,
  output logic [63:0] cache_data_in,
  input  logic [63:0] cache_data,
  input  logic        cache_valid,
  input  logic        cache_ready
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, redir_pc;
  logic            pend_q, pend_d, flt_q, flt_d;
  logic            accept, miss, push, pop, fifo_empty, redir_bad;
  logic [CntW-1:0] fifo_count;
  fifo_entry_t     push_entry, head;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign out_fault = out_valid & head.fault;
`else
  assign redir_pc  = {redirect_pc[PC_W-1:2], 2'b00};
  assign redir_bad = 1'b0;
  logic unused_fault;
  assign unused_fault = head.fault;
`endif

  logic unused_data_hi;
  assign unused_data_hi = ^cache_data[63:32];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = redir_bad ? StHalt : StFetch;
    end else begin
      unique case (state_q)
        StFetch:    if (miss) state_d = StMissWait;
        StMissWait: if (!miss && cache_ready) state_d = StFetch;
        StHalt:     state_d = StHalt;
        default:    state_d = StFetch;
      endcase
    end
  end

  // Outputs: occupancy counts the in-flight beat but not a same-cycle pop.
  always_comb begin
    cache_read = 1'b0;
    if (!rst && state_q != StHalt && !redirect_valid && cache_ready) begin
      cache_read = (32'(fifo_count) + 32'(pend_q)) < FIFO_DEPTH;
    end
  end

  assign accept = cache_read & cache_valid;
  assign miss   = cache_read & ~cache_valid;

  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = 1'b0;
    flt_d     = 1'b0;
    if (redirect_valid) begin
      pc_d  = redir_pc;
      flt_d = redir_bad;
    end else begin
      pend_d = accept;
      if (accept) begin
        pend_pc_d = pc_q;
        pc_d      = pc_q + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      pend_q    <= 1'b0;
      flt_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      flt_q     <= flt_d;
    end
  end

  // A trapped redirect leaves its PC in pc_q while halted; that becomes the fault entry.
  always_comb begin
    push_entry = '{pc: pend_pc_q, inst: cache_data[INST_W-1:0], fault: 1'b0};
    if (flt_q) push_entry = '{pc: pc_q, inst: NOP_INST, fault: 1'b1};
  end

  assign push      = ~redirect_valid & (pend_q | flt_q);
  assign out_valid = ~rst & ~fifo_empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;

  ifu_fifo #(
    .Depth (FIFO_DEPTH),
    .Width ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_pc          = head.pc;
  assign out_inst        = head.inst;
  assign cache_addr      = pc_q;
  assign cache_write     = 1'b0;
  assign cache_write_len = 2'b10;
  assign cache_data_in   = '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch against a queue-based model of the fetch/buffer rules.
module tb_ifu_fetch;

  localparam int unsigned DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        out_fault;
`endif
  logic [63:0] cache_addr;
  logic        cache_read;
  logic        cache_write;
  logic [1:0]  cache_write_len;
  logic [63:0] cache_data_in;
  logic [63:0] cache_data;
  logic        cache_valid;
  logic        cache_ready;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
`ifdef IFU_MISALIGN_CHECK_EN
    .out_fault       (out_fault),
`endif
    .cache_addr      (cache_addr),
    .cache_read      (cache_read),
    .cache_write     (cache_write),
    .cache_write_len (cache_write_len),
    .cache_data_in   (cache_data_in),
    .cache_data      (cache_data),
    .cache_valid     (cache_valid),
    .cache_ready     (cache_ready)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: PC, in-flight beat and the buffered instructions in order.
  logic [63:0] m_pc;
  logic [63:0] m_pend_pc;
  bit          m_pend;
  ent_t        m_q[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    cache_ready = 1'b0;
    cache_valid = 1'b0;
    cache_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cache_read", cache_read, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at the falling edge, compare after settling, then advance the model.
  task automatic step(input bit rv, input logic [63:0] rpc, input bit ordy, input bit crdy,
                      input bit cval);
    bit exp_read, exp_ov, acc;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    cache_ready    = crdy;
    cache_valid    = cval;
    cache_data     = {$urandom(), m_pend ? inst_of(m_pend_pc) : $urandom()};
    #1;
    exp_read = !rv && crdy && ((m_q.size() + int'(m_pend)) < DEPTH);
    exp_ov   = (m_q.size() != 0) && !rv;
    chk("cache_read", cache_read, exp_read);
    chk("cache_addr", cache_addr, m_pc);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_inst", out_inst, m_q[0].inst);
`ifdef IFU_MISALIGN_CHECK_EN
      chk("out_fault", out_fault, 0);
`endif
    end
    chk("cache_tieoffs", {cache_data_in[60:0], cache_write, cache_write_len}, 64'h2);
    acc = exp_read && cval;
    if (rv) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = {rpc[63:2], 2'b00};
    end else begin
      if (exp_ov && ordy) void'(m_q.pop_front());
      if (m_pend) m_q.push_back('{pc: m_pend_pc, inst: inst_of(m_pend_pc)});
      m_pend = acc;
      if (acc) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 64'd4;
      end
    end
  endtask

  initial begin
    bit          missed;
    int          dut_acc;
    bit          rv, ordy, crdy, cval;
    logic [63:0] rpc;

    // Streaming with every access hitting
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, '0, 1, 1, 1);
      if (i == 0) begin
        chk("a_addr0", cache_addr, 64'h8000_0000);
        chk("a_ov0", out_valid, 0);
      end
      if (i == 1) chk("a_addr1", cache_addr, 64'h8000_0004);
      if (i == 2) chk("a_pc2", out_pc, 64'h8000_0000);
      if (i == 3) chk("a_pc3", out_pc, 64'h8000_0004);
    end

    // Miss at 0x8000_0008 followed by a 10-cycle refill
    do_reset();
    missed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!missed && m_pc == 64'h8000_0008 && (m_q.size() + int'(m_pend)) < DEPTH) begin
        step(0, '0, 1, 1, 0);
        missed = 1'b1;
        repeat (10) begin
          step(0, '0, 1, 0, 1);
          chk("b_refill_read", cache_read, 0);
        end
        step(0, '0, 1, 1, 1);
        chk("b_reissue_addr", cache_addr, 64'h8000_0008);
        chk("b_reissue_read", cache_read, 1);
      end else begin
        step(0, '0, 1, 1, 1);
      end
    end

    // Backpressure: only DEPTH accepts before issue stalls
    do_reset();
    dut_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 0, 1, 1);
      dut_acc += int'(cache_read);
    end
    chk("c_accepts", dut_acc, DEPTH);
    chk("c_read_low", cache_read, 0);
    step(0, '0, 1, 1, 1);
    chk("c_first_pc", out_pc, 64'h8000_0000);
    repeat (8) step(0, '0, 1, 1, 1);

    // Redirect while a beat is in flight
    do_reset();
    step(0, '0, 1, 1, 1);
    step(1, 64'h8000_0100, 1, 1, 1);
    step(0, '0, 1, 1, 1);
    chk("d_empty", out_valid, 0);
    chk("d_addr", cache_addr, 64'h8000_0100);
    step(0, '0, 1, 1, 1);
    step(0, '0, 1, 1, 1);
    chk("d_ov", out_valid, 1);
    chk("d_pc", out_pc, 64'h8000_0100);

    // PC wraps past the top of the address space
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1);
    step(0, '0, 1, 1, 1);
    chk("e_addr_top", cache_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, '0, 1, 1, 1);
    chk("e_addr_wrap", cache_addr, 64'h0);
    repeat (4) step(0, '0, 1, 1, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rv   = ($urandom_range(99) < 4);
      ordy = ($urandom_range(99) < 60);
      crdy = ($urandom_range(99) < 80);
      cval = ($urandom_range(99) < 70);
      if ($urandom_range(3) == 0) rpc = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom())};
      else rpc = {32'h0, 16'h8000, 16'($urandom())};
`ifdef IFU_MISALIGN_CHECK_EN
      rpc[1:0] = 2'b00;
`endif
      step(rv, rpc, ordy, crdy, cval);
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Misaligned redirect traps and halts until an aligned redirect
    do_reset();
    step(0, '0, 1, 1, 1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0102;
    cache_ready = 1'b1;
    cache_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("g_read_r1", cache_read, 0);
    @(negedge clk);
    #1;
    chk("g_ov", out_valid, 1);
    chk("g_fault", out_fault, 1);
    chk("g_inst", out_inst, 32'h0000_0013);
    chk("g_pc", out_pc, 64'h8000_0102);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("g_halt_read", cache_read, 0);
      chk("g_halt_ov", out_valid, 0);
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("g_resume_read", cache_read, 1);
    chk("g_resume_addr", cache_addr, 64'h8000_0200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
